// File: rtl/actor_step_scheduler.sv
// Frame tick generator and per-frame actor step scheduler: fractional speed accumulators
// decide which actors advance, and due steps are issued one at a time over valid/ready.
module actor_step_scheduler #(
    parameter int CLK_HZ     = 25000000,
    parameter int FRAME_HZ   = 60,
    parameter int NUM_ACTORS = 5,
    parameter int SPEED_W    = 7,
    parameter int SPEED_FULL = 100
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            pause,
    input  logic [NUM_ACTORS*SPEED_W-1:0]   speed,
    input  logic                            step_ready,
    input  logic                            overrun_clr,
    output logic                            frame_tick,
    output logic                            step_valid,
    output logic [$clog2(NUM_ACTORS)-1:0]   step_id,
    output logic                            busy,
    output logic                            overrun
);
    localparam int DIV   = CLK_HZ / FRAME_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ID_W  = $clog2(NUM_ACTORS);
    localparam int ACC_W = SPEED_W + 1;
    localparam int SUM_W = SPEED_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_ACTORS - 1);
    localparam logic [SUM_W-1:0] FULL     = SUM_W'(SPEED_FULL);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ISSUE
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          frame_tick_q;
    logic [ID_W-1:0]               idx_q, idx_d;
    logic [NUM_ACTORS*SPEED_W-1:0] snap_q, snap_d;
    logic [ACC_W-1:0]              acc_q [NUM_ACTORS];
    logic [ACC_W-1:0]              acc_d [NUM_ACTORS];
    logic                          step_valid_q, step_valid_d;
    logic [ID_W-1:0]               step_id_q, step_id_d;
    logic                          overrun_q, overrun_d;

    logic                          tick_int;
    logic [SPEED_W-1:0]            cur_speed;
    logic [SUM_W-1:0]              eff_speed;
    logic [SUM_W-1:0]              sum;

    always_comb begin
        tick_int = (cnt_q == CNT_LAST);
        cnt_d    = tick_int ? '0 : cnt_q + CNT_W'(1);
    end

    // Speeds above full are clamped so an actor never takes two steps in one frame.
    always_comb begin
        cur_speed = snap_q[int'(idx_q)*SPEED_W +: SPEED_W];
        eff_speed = (SUM_W'(cur_speed) > FULL) ? FULL : SUM_W'(cur_speed);
        sum       = SUM_W'(acc_q[idx_q]) + eff_speed;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        acc_d        = acc_q;
        step_valid_d = step_valid_q;
        step_id_d    = step_id_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (tick_int && enable && !pause) begin
                    snap_d  = speed;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (sum >= FULL) begin
                    acc_d[idx_q] = ACC_W'(sum - FULL);
                    step_valid_d = 1'b1;
                    step_id_d    = idx_q;
                    state_d      = ISSUE;
                end else begin
                    acc_d[idx_q] = ACC_W'(sum);
                    if (idx_q == ID_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + ID_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (step_ready) begin
                    step_valid_d = 1'b0;
                    if (idx_q == ID_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + ID_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick landing mid-scan is dropped; setting takes priority over clearing.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (tick_int && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        if (!enable) begin
            state_d      = IDLE;
            step_valid_d = 1'b0;
            for (int i = 0; i < NUM_ACTORS; i++) begin
                acc_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
            idx_q        <= '0;
            snap_q       <= '0;
            step_valid_q <= 1'b0;
            step_id_q    <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_ACTORS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_tick_q <= tick_int;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            step_valid_q <= step_valid_d;
            step_id_q    <= step_id_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < NUM_ACTORS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign frame_tick = frame_tick_q;
    assign step_valid = step_valid_q;
    assign step_id    = step_id_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_actor_step_scheduler.sv
// Self-checking bench for actor_step_scheduler: frame table with a step scoreboard,
// plus hand-written stall, pause/disable and async reset sequences.
module tb_actor_step_scheduler;
    localparam int N       = 5;
    localparam int W       = 7;
    localparam int N_ROWS  = 19;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           pause;
    logic [N*W-1:0] speed;
    logic           step_ready;
    logic           overrun_clr;
    logic           frame_tick;
    logic           step_valid;
    logic [2:0]     step_id;
    logic           busy;
    logic           overrun;

    always #5 clk = ~clk;

    actor_step_scheduler #(
        .CLK_HZ    (1000),
        .FRAME_HZ  (100),
        .NUM_ACTORS(N),
        .SPEED_W   (W),
        .SPEED_FULL(100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pause      (pause),
        .speed      (speed),
        .step_ready (step_ready),
        .overrun_clr(overrun_clr),
        .frame_tick (frame_tick),
        .step_valid (step_valid),
        .step_id    (step_id),
        .busy       (busy),
        .overrun    (overrun)
    );

    typedef struct {
        logic [N*W-1:0] spd;
        bit             pse;
        bit             ovr;
        logic [N-1:0]   mask;
    } vec_t;

    typedef struct {
        int id;
        int rel;
    } exp_t;

    vec_t tbl [N_ROWS];
    exp_t exp_q [$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc       = 0;
    int ftick_cyc = 0;
    int s_ftick, s_valid, s_id, s_busy, s_ovr;

    function automatic logic [N*W-1:0] pack_speeds(int s0, int s1, int s2, int s3, int s4);
        return {7'(s4), 7'(s3), 7'(s2), 7'(s1), 7'(s0)};
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic [N*W-1:0] spd, input bit pse);
        speed = spd;
        pause = pse;
    endtask

    // Samples outputs on the falling edge; a valid&&ready seen here is the handshake of the next rising edge.
    task automatic step_cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        s_ftick = int'(frame_tick);
        s_valid = int'(step_valid);
        s_id    = int'(step_id);
        s_busy  = int'(busy);
        s_ovr   = int'(overrun);
        if (s_ftick != 0) begin
            ftick_cyc = cyc;
        end
        if ((s_valid != 0) && step_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_step", s_id, -1);
            end else begin
                e = exp_q.pop_front();
                check_output("step_id", s_id, e.id);
                if (e.rel >= 0) begin
                    check_output("step_latency", cyc - ftick_cyc, e.rel);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int got;
        got = 0;
        for (int i = 0; i < 25 && got == 0; i++) begin
            step_cycle();
            got = s_ftick;
        end
        check_output("frame_tick_seen", got, 1);
    endtask

    // Skipped actors cost one cycle, stepping actors two; the first valid is one cycle after frame_tick.
    task automatic push_mask(input logic [N-1:0] m);
        int rel;
        exp_t e;
        rel = 1;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                e.id  = i;
                e.rel = rel;
                exp_q.push_back(e);
                rel += 2;
            end else begin
                rel += 1;
            end
        end
    endtask

    task automatic push_one(input int id, input int rel);
        exp_t e;
        e.id  = id;
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    initial begin
        int hold_err;

        tbl[0]  = '{pack_speeds(100, 100, 100, 100, 100), 1'b0, 1'b0, 5'b11111};
        tbl[1]  = '{pack_speeds(100, 100, 100, 100, 100), 1'b0, 1'b1, 5'b00000};
        tbl[2]  = '{pack_speeds(0, 75, 0, 0, 0),          1'b0, 1'b0, 5'b00000};
        tbl[3]  = '{pack_speeds(0, 75, 0, 0, 0),          1'b0, 1'b0, 5'b00010};
        tbl[4]  = '{pack_speeds(0, 75, 0, 0, 0),          1'b0, 1'b0, 5'b00010};
        tbl[5]  = '{pack_speeds(0, 75, 0, 0, 0),          1'b0, 1'b0, 5'b00010};
        tbl[6]  = '{pack_speeds(0, 75, 0, 0, 0),          1'b0, 1'b0, 5'b00000};
        tbl[7]  = '{pack_speeds(0, 120, 0, 0, 0),         1'b0, 1'b0, 5'b00010};
        tbl[8]  = '{pack_speeds(0, 120, 0, 0, 0),         1'b0, 1'b0, 5'b00010};
        tbl[9]  = '{pack_speeds(100, 0, 50, 100, 30),     1'b0, 1'b0, 5'b01001};
        tbl[10] = '{pack_speeds(100, 0, 50, 100, 30),     1'b0, 1'b0, 5'b01101};
        tbl[11] = '{pack_speeds(100, 0, 50, 100, 30),     1'b0, 1'b0, 5'b01001};
        tbl[12] = '{pack_speeds(100, 0, 50, 100, 30),     1'b0, 1'b0, 5'b11101};
        tbl[13] = '{pack_speeds(0, 0, 50, 0, 0),          1'b0, 1'b0, 5'b00000};
        tbl[14] = '{pack_speeds(0, 0, 50, 0, 0),          1'b1, 1'b0, 5'b00000};
        tbl[15] = '{pack_speeds(0, 0, 50, 0, 0),          1'b1, 1'b0, 5'b00000};
        tbl[16] = '{pack_speeds(0, 0, 50, 0, 0),          1'b1, 1'b0, 5'b00000};
        tbl[17] = '{pack_speeds(0, 0, 50, 0, 0),          1'b0, 1'b0, 5'b00100};
        tbl[18] = '{pack_speeds(0, 0, 50, 0, 0),          1'b0, 1'b0, 5'b00000};

        reset       = 1'b0;
        enable      = 1'b0;
        pause       = 1'b0;
        speed       = '0;
        step_ready  = 1'b1;
        overrun_clr = 1'b0;
        repeat (3) step_cycle();
        check_output("reset_frame_tick", s_ftick, 0);
        check_output("reset_step_valid", s_valid, 0);
        check_output("reset_busy", s_busy, 0);
        check_output("reset_overrun", s_ovr, 0);

        $display("[TB] prescaler after reset release, enable low");
        reset = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            step_cycle();
            check_output("frame_tick_period", s_ftick, (k > 0 && k % 10 == 0) ? 1 : 0);
        end
        check_output("disabled_step_valid", s_valid, 0);
        check_output("disabled_busy", s_busy, 0);
        check_output("disabled_overrun", s_ovr, 0);

        $display("[TB] frame table");
        enable = 1'b1;
        apply_stimulus(tbl[0].spd, tbl[0].pse);
        for (int r = 0; r < N_ROWS; r++) begin
            wait_tick();
            check_output("overrun_row", s_ovr, int'(tbl[r].ovr));
            check_output("pending_steps", exp_q.size(), 0);
            push_mask(tbl[r].mask);
            if (tbl[r].ovr) begin
                overrun_clr = 1'b1;
            end
            if (r + 1 < N_ROWS) begin
                apply_stimulus(tbl[r + 1].spd, tbl[r + 1].pse);
            end
            step_cycle();
            overrun_clr = 1'b0;
        end

        $display("[TB] enable drop clears accumulators");
        repeat (6) step_cycle();
        check_output("idle_before_disable", s_busy, 0);
        enable = 1'b0;
        step_cycle();
        enable = 1'b1;
        wait_tick();
        check_output("pending_after_reenable", exp_q.size(), 0);
        wait_tick();
        check_output("pending_frame_b", exp_q.size(), 0);
        push_one(2, 3);
        wait_tick();
        check_output("second_frame_step_done", exp_q.size(), 0);

        $display("[TB] stalled handshake");
        apply_stimulus(pack_speeds(100, 0, 0, 0, 0), 1'b0);
        step_ready = 1'b0;
        wait_tick();
        push_one(0, -1);
        hold_err = 0;
        for (int i = 0; i < 15; i++) begin
            step_cycle();
            if (!(s_valid == 1 && s_id == 0)) begin
                hold_err++;
            end
        end
        check_output("stall_hold_errors", hold_err, 0);
        check_output("overrun_on_busy_tick", s_ovr, 1);
        step_ready = 1'b1;
        apply_stimulus(pack_speeds(0, 0, 0, 0, 0), 1'b0);
        repeat (12) step_cycle();
        check_output("stall_step_taken", exp_q.size(), 0);
        check_output("scan_finished_busy", s_busy, 0);
        check_output("overrun_sticky", s_ovr, 1);
        overrun_clr = 1'b1;
        step_cycle();
        overrun_clr = 1'b0;
        step_cycle();
        check_output("overrun_cleared", s_ovr, 0);

        $display("[TB] async reset during a pending step");
        apply_stimulus(pack_speeds(100, 0, 0, 0, 0), 1'b0);
        step_ready = 1'b0;
        wait_tick();
        wait_tick();
        push_one(0, -1);
        repeat (10) step_cycle();
        check_output("pre_reset_valid", s_valid, 1);
        check_output("pre_reset_overrun", s_ovr, 1);
        #1;
        reset = 1'b0;
        #1;
        check_output("async_step_valid", int'(step_valid), 0);
        check_output("async_busy", int'(busy), 0);
        check_output("async_overrun", int'(overrun), 0);
        exp_q.delete();
        repeat (2) step_cycle();
        step_ready = 1'b1;
        apply_stimulus(pack_speeds(0, 0, 0, 0, 0), 1'b0);
        reset = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            step_cycle();
            check_output("first_tick_after_reset", s_ftick, (k == 10) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
